// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit word access split into two 16-bit SRAM phases with wait states
module sram_controller #(
    parameter int ADDR_BASE   = 1024,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               op_wr_q, op_wr_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [15:0]        low_q;
    logic [31:0]        read_data_q;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               dq_oe_q, dq_oe_d;
    logic               we_n_q, we_n_d;
    logic               oe_n_q, oe_n_d;
    logic               req;
    logic               last;
    logic [31:0]        sub;
    logic               unused_sub;

    assign req  = wr_en | rd_en;
    assign last = (cnt_q == CNT_LAST);

    // Request fields are taken straight from the inputs in IDLE so the pins can be
    // set up on the same edge that enters LOW; afterwards the latched copy is used.
    assign addr_d  = (state_q == IDLE) ? address    : addr_q;
    assign wdata_d = (state_q == IDLE) ? write_data : wdata_q;
    assign op_wr_d = (state_q == IDLE) ? wr_en      : op_wr_q;

    // Byte offset from the base, modulo 2^32; bits [1:0] are the byte lane, upper bits wrap away.
    assign sub        = addr_d - 32'(ADDR_BASE);
    assign unused_sub = &{1'b0, sub[31:SRAM_AW+1], sub[1:0]};

    // State and phase-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and phase-counter decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (req) state_d = LOW;
            end
            LOW: begin
                if (last) begin
                    cnt_d   = 4'd0;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HIGH: begin
                if (last) begin
                    cnt_d   = 4'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SRAM pin values decoded from the state being entered
    always_comb begin
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        if (state_d == LOW || state_d == HIGH) begin
            sram_addr_d = {sub[SRAM_AW:2], (state_d == HIGH)};
            if (op_wr_d) begin
                dq_out_d = (state_d == HIGH) ? wdata_d[31:16] : wdata_d[15:0];
                dq_oe_d  = 1'b1;
                we_n_d   = 1'b0;
            end else begin
                oe_n_d   = 1'b0;
            end
        end
    end

    // Request latch, registered SRAM pins and load-word assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            low_q       <= 16'd0;
            read_data_q <= 32'd0;
            sram_addr_q <= '0;
            dq_out_q    <= 16'd0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            op_wr_q     <= op_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            if (state_q == LOW && last && !op_wr_q) begin
                low_q <= sram_dq_in;
            end
            if (state_q == HIGH && last && !op_wr_q) begin
                read_data_q <= {sram_dq_in, low_q};
            end
        end
    end

    assign ready       = ~req | (state_q == DONE);
    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed checks of sram_controller at WAIT_CYCLES 2 and 1
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst, wr_en, rd_en;
    logic [31:0] address, write_data;

    logic [31:0] rd_a, rd_b;
    logic        rdy_a, rdy_b;
    logic [17:0] addr_a, addr_b;
    logic [15:0] dqo_a, dqo_b, dqi_a, dqi_b;
    logic        oe_a, oe_b, wen_a, wen_b, oen_a, oen_b;

    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_controller #(.ADDR_BASE(1024), .SRAM_AW(18), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data),
        .read_data(rd_a), .ready(rdy_a), .sram_addr(addr_a),
        .sram_dq_out(dqo_a), .sram_dq_oe(oe_a), .sram_dq_in(dqi_a),
        .sram_we_n(wen_a), .sram_oe_n(oen_a)
    );

    sram_controller #(.ADDR_BASE(1024), .SRAM_AW(18), .WAIT_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data),
        .read_data(rd_b), .ready(rdy_b), .sram_addr(addr_b),
        .sram_dq_out(dqo_b), .sram_dq_oe(oe_b), .sram_dq_in(dqi_b),
        .sram_we_n(wen_b), .sram_oe_n(oen_b)
    );

    // Small SRAM models indexed by the low address bits
    always @(posedge clk) begin
        if (!wen_a) mem_a[addr_a[3:0]] <= dqo_a;
        if (!wen_b) mem_b[addr_b[3:0]] <= dqo_b;
    end
    assign dqi_a = oen_a ? 16'h0000 : mem_a[addr_a[3:0]];
    assign dqi_b = oen_b ? 16'h0000 : mem_b[addr_b[3:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 16'h0000;
            mem_b[i] = 16'h0000;
        end
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b0;
        address = 32'd1032; write_data = 32'hDEAD_BEEF;

        // 1: reset with a request held
        cyc(); cyc();
        chk("rst_read_data", rd_a, 32'h0);
        chk("rst_sram_addr", 32'(addr_a), 32'h0);
        chk("rst_dq_out", 32'(dqo_a), 32'h0);
        chk("rst_dq_oe", 32'(oe_a), 32'h0);
        chk("rst_we_n", 32'(wen_a), 32'h1);
        chk("rst_oe_n", 32'(oen_a), 32'h1);
        chk("rst_ready_req", 32'(rdy_a), 32'h0);

        // 2: write 0xDEADBEEF to byte 1032 -> halfwords 4 and 5
        rst = 1'b0;
        #1;
        chk("wr_c0_ready", 32'(rdy_a), 32'h0);
        cyc();
        chk("wr_c1_addr", 32'(addr_a), 32'd4);
        chk("wr_c1_dq", 32'(dqo_a), 32'hBEEF);
        chk("wr_c1_we_n", 32'(wen_a), 32'h0);
        chk("wr_c1_dq_oe", 32'(oe_a), 32'h1);
        chk("wr_c1_ready", 32'(rdy_a), 32'h0);
        cyc();
        chk("wr_c2_addr", 32'(addr_a), 32'd4);
        chk("wr_c2_we_n", 32'(wen_a), 32'h0);
        cyc();
        chk("wr_c3_addr", 32'(addr_a), 32'd5);
        chk("wr_c3_dq", 32'(dqo_a), 32'hDEAD);
        chk("wr_c3_we_n", 32'(wen_a), 32'h0);
        cyc();
        chk("wr_c4_addr", 32'(addr_a), 32'd5);
        chk("wr_c4_ready", 32'(rdy_a), 32'h0);
        cyc();
        chk("wr_c5_ready", 32'(rdy_a), 32'h1);
        chk("wr_c5_we_n", 32'(wen_a), 32'h1);
        chk("wr_c5_dq_oe", 32'(oe_a), 32'h0);
        wr_en = 1'b0;
        cyc();

        // 3: read the same word back
        rd_en = 1'b1;
        #1;
        chk("rd_c0_ready", 32'(rdy_a), 32'h0);
        cyc();
        chk("rd_c1_oe_n", 32'(oen_a), 32'h0);
        chk("rd_c1_we_n", 32'(wen_a), 32'h1);
        chk("rd_c1_dq_oe", 32'(oe_a), 32'h0);
        chk("rd_c1_addr", 32'(addr_a), 32'd4);
        cyc();
        cyc();
        chk("rd_c3_addr", 32'(addr_a), 32'd5);
        chk("rd_c3_oe_n", 32'(oen_a), 32'h0);
        cyc();
        cyc();
        chk("rd_done_data", rd_a, 32'hDEAD_BEEF);
        chk("rd_done_oe_n", 32'(oen_a), 32'h1);
        chk("rd_done_ready", 32'(rdy_a), 32'h1);
        rd_en = 1'b0;
        cyc();
        chk("rd_hold_data", rd_a, 32'hDEAD_BEEF);

        // 4: simultaneous wr_en and rd_en -> write wins
        wr_en = 1'b1; rd_en = 1'b1; write_data = 32'h1234_5678;
        cyc();
        chk("both_we_n", 32'(wen_a), 32'h0);
        chk("both_oe_n", 32'(oen_a), 32'h1);
        chk("both_dq", 32'(dqo_a), 32'h5678);
        cyc(); cyc();
        chk("both_hi_dq", 32'(dqo_a), 32'h1234);
        cyc(); cyc();
        chk("both_done_ready", 32'(rdy_a), 32'h1);
        chk("both_read_data", rd_a, 32'hDEAD_BEEF);
        wr_en = 1'b0; rd_en = 1'b0;
        cyc();
        chk("both_mem_lo", 32'(mem_a[4]), 32'h5678);

        // 5: reset during HIGH of a read
        rd_en = 1'b1;
        cyc(); cyc(); cyc();
        chk("abort_in_high", 32'(addr_a), 32'd5);
        rst = 1'b1; rd_en = 1'b0;
        cyc();
        chk("abort_we_n", 32'(wen_a), 32'h1);
        chk("abort_oe_n", 32'(oen_a), 32'h1);
        chk("abort_read_data", rd_a, 32'h0);
        chk("abort_ready", 32'(rdy_a), 32'h1);
        rst = 1'b0;
        cyc();
        chk("abort_no_done_data", rd_a, 32'h0);
        chk("abort_idle_oe_n", 32'(oen_a), 32'h1);

        // 6: back-to-back write/read at address 0 with one wait cycle
        wr_en = 1'b1; address = 32'd0; write_data = 32'hA5A5_5A5A;
        #1;
        chk("b2b_w_c0_ready", 32'(rdy_b), 32'h0);
        cyc();
        chk("b2b_w_c1_addr", 32'(addr_b), 32'h3FE00);
        chk("b2b_w_c1_dq", 32'(dqo_b), 32'h5A5A);
        chk("b2b_w_c1_ready", 32'(rdy_b), 32'h0);
        cyc();
        chk("b2b_w_c2_addr", 32'(addr_b), 32'h3FE01);
        chk("b2b_w_c2_dq", 32'(dqo_b), 32'hA5A5);
        chk("b2b_w_c2_ready", 32'(rdy_b), 32'h0);
        cyc();
        chk("b2b_w_done_ready", 32'(rdy_b), 32'h1);
        wr_en = 1'b0; rd_en = 1'b1;
        cyc();
        chk("b2b_r_c0_ready", 32'(rdy_b), 32'h0);
        cyc();
        chk("b2b_r_c1_addr", 32'(addr_b), 32'h3FE00);
        chk("b2b_r_c1_oe_n", 32'(oen_b), 32'h0);
        chk("b2b_r_c1_ready", 32'(rdy_b), 32'h0);
        cyc();
        chk("b2b_r_c2_addr", 32'(addr_b), 32'h3FE01);
        chk("b2b_r_c2_ready", 32'(rdy_b), 32'h0);
        cyc();
        chk("b2b_r_done_ready", 32'(rdy_b), 32'h1);
        chk("b2b_r_data", rd_b, 32'hA5A5_5A5A);
        rd_en = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
